// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: loads the start PC from the reset vector,
// walks memory one byte per cycle, sizes each opcode (1-3 bytes) and hands
// the assembled instruction to the decoder over a valid/ready handshake.
// Ports:
//   clk, rst                        clock, async active-high reset
//   data[7:0]                       memory read data for addr (same cycle)
//   addr[15:0]                      registered fetch address
//   redirect_valid, redirect_pc     new fetch target from execute
//   instr_valid, instr_ready        decoder handshake
//   instr_opcode/op1/op2/len/pc     instruction payload
module fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  output logic [15:0] addr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_op1,
  output logic [7:0]  instr_op2,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc
);

  typedef enum logic [2:0] {
    RST_LO,
    RST_HI,
    FETCH_OP,
    FETCH_B1,
    FETCH_B2,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  vec_lo_q, vec_lo_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  op1_q, op1_d;
  logic [7:0]  op2_q, op2_d;
  logic [1:0]  len_q, len_d;
  logic [15:0] pc_q, pc_d;
  logic [1:0]  data_len;

  // Opcode aaabbbcc: length decoded from the cc group and bbb mode field.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [2:0] bbb;
    logic [1:0] len;
    bbb = op[4:2];
    len = 2'd1;
    case (op[1:0])
      2'b01: begin
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd3;
        else len = 2'd2;
      end
      2'b10: begin
        if (bbb == 3'b011 || bbb == 3'b111) len = 2'd3;
        else if (bbb == 3'b000 || bbb == 3'b001 || bbb == 3'b101) len = 2'd2;
        else len = 2'd1;
      end
      2'b00: begin
        if (op == 8'h20) len = 2'd3;
        else if (op == 8'h00 || op == 8'h40 || op == 8'h60) len = 2'd1;
        else if (bbb == 3'b000) len = 2'd2;
        else if (bbb == 3'b011 || bbb == 3'b111) len = 2'd3;
        else if (bbb == 3'b001 || bbb == 3'b100 || bbb == 3'b101) len = 2'd2;
        else len = 2'd1;
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  assign data_len = op_len(data);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    vec_lo_d = vec_lo_q;
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    len_d    = len_q;
    pc_d     = pc_q;
    case (state_q)
      RST_LO: begin
        vec_lo_d = data;
        addr_d   = RESET_VECTOR + 16'd1;
        state_d  = RST_HI;
      end
      RST_HI: begin
        addr_d  = {data, vec_lo_q};
        state_d = FETCH_OP;
      end
      FETCH_OP: begin
        opcode_d = data;
        pc_d     = addr_q;
        op1_d    = 8'h00;
        op2_d    = 8'h00;
        len_d    = data_len;
        addr_d   = addr_q + 16'd1;
        state_d  = (data_len == 2'd1) ? HOLD : FETCH_B1;
      end
      FETCH_B1: begin
        op1_d   = data;
        addr_d  = addr_q + 16'd1;
        state_d = (len_q == 2'd2) ? HOLD : FETCH_B2;
      end
      FETCH_B2: begin
        op2_d   = data;
        addr_d  = addr_q + 16'd1;
        state_d = HOLD;
      end
      HOLD: begin
        if (instr_ready) state_d = FETCH_OP;
      end
      default: state_d = RST_LO;
    endcase
    // A redirect drops whatever is in flight; the payload registers keep
    // their old contents since instr_valid is low until the next HOLD.
    if (redirect_valid && state_q != RST_LO && state_q != RST_HI) begin
      addr_d   = redirect_pc;
      state_d  = FETCH_OP;
      opcode_d = opcode_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      len_d    = len_q;
      pc_d     = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RST_LO;
      addr_q   <= RESET_VECTOR;
      vec_lo_q <= 8'h00;
      opcode_q <= 8'h00;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
      len_q    <= 2'd1;
      pc_q     <= 16'h0000;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      vec_lo_q <= vec_lo_d;
      opcode_q <= opcode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      len_q    <= len_d;
      pc_q     <= pc_d;
    end
  end

  assign addr         = addr_q;
  assign instr_valid  = (state_q == HOLD);
  assign instr_opcode = opcode_q;
  assign instr_op1    = op1_q;
  assign instr_op2    = op2_q;
  assign instr_len    = len_q;
  assign instr_pc     = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset vector load, instruction stream
// timing, length table, backpressure, redirects, address wrap, async reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic [15:0] addr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_op1;
  logic [7:0]  instr_op2;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;

  logic [7:0] mem [0:65535];

  int nerr = 0;
  int nchk = 0;

  fetch_unit #(.RESET_VECTOR(16'hFFFC)) dut (
    .clk            (clk),
    .rst            (rst),
    .data           (data),
    .addr           (addr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_op1      (instr_op1),
    .instr_op2      (instr_op2),
    .instr_len      (instr_len),
    .instr_pc       (instr_pc)
  );

  assign data = mem[addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cyc;
    logic [7:0]  op;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [1:0]  len;
    logic [15:0] pc;
  } svec_t;

  typedef struct {
    logic [7:0] op;
    logic [1:0] len;
  } lvec_t;

  svec_t sv [3];
  lvec_t lt [23];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_valid(input int lim);
    int n;
    n = 0;
    while (!instr_valid && n < lim) begin
      step();
      n++;
    end
    chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    logic [15:0] p;
    int k;
    logic ev;

    sv[0] = '{1, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000};
    sv[1] = '{4, 8'hA9, 8'h05, 8'h00, 2'd2, 16'h8001};
    sv[2] = '{8, 8'h8D, 8'h00, 8'h02, 2'd3, 16'h8003};

    lt[0]  = '{8'hEA, 2'd1};
    lt[1]  = '{8'hA9, 2'd2};
    lt[2]  = '{8'h8D, 2'd3};
    lt[3]  = '{8'h20, 2'd3};
    lt[4]  = '{8'h00, 2'd1};
    lt[5]  = '{8'h40, 2'd1};
    lt[6]  = '{8'h60, 2'd1};
    lt[7]  = '{8'hA2, 2'd2};
    lt[8]  = '{8'h0A, 2'd1};
    lt[9]  = '{8'h4C, 2'd3};
    lt[10] = '{8'h6C, 2'd3};
    lt[11] = '{8'h10, 2'd2};
    lt[12] = '{8'h24, 2'd2};
    lt[13] = '{8'h18, 2'd1};
    lt[14] = '{8'hBC, 2'd3};
    lt[15] = '{8'hB1, 2'd2};
    lt[16] = '{8'hB9, 2'd3};
    lt[17] = '{8'hBD, 2'd3};
    lt[18] = '{8'h9A, 2'd1};
    lt[19] = '{8'hBE, 2'd3};
    lt[20] = '{8'hB6, 2'd2};
    lt[21] = '{8'h03, 2'd1};
    lt[22] = '{8'hA0, 2'd2};

    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hEA;
    mem[16'h8001] = 8'hA9;
    mem[16'h8002] = 8'h05;
    mem[16'h8003] = 8'h8D;
    mem[16'h8004] = 8'h00;
    mem[16'h8005] = 8'h02;
    p = 16'h8006;
    for (int i = 0; i < 23; i++) begin
      mem[p] = lt[i].op;
      if (lt[i].len >= 2'd2) mem[p + 16'd1] = 8'h10 + 8'(i);
      if (lt[i].len == 2'd3) mem[p + 16'd2] = 8'hC0 + 8'(i);
      p = p + 16'(lt[i].len);
    end
    mem[16'h9000] = 8'hA9;
    mem[16'h9001] = 8'h77;
    mem[16'h9002] = 8'hEA;
    mem[16'hA000] = 8'h4C;
    mem[16'hA001] = 8'h11;
    mem[16'hA002] = 8'h22;
    mem[16'hC000] = 8'hEA;
    mem[16'hC100] = 8'hA9;
    mem[16'hC101] = 8'h33;
    mem[16'hC200] = 8'hEA;
    mem[16'hFFFE] = 8'h20;
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;
    mem[16'h0001] = 8'hEA;
    mem[16'hD000] = 8'h8D;
    mem[16'hD001] = 8'h44;
    mem[16'hD002] = 8'h55;

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = 1'b1;
    step();
    step();
    chk("rst_addr", addr, 16'hFFFC);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_opcode", instr_opcode, 8'h00);
    chk("rst_len", instr_len, 2'd1);
    chk("rst_pc", instr_pc, 16'h0000);
    rst = 1'b0;

    chk("vec_c0", addr, 16'hFFFC);
    chk("vec_c0_valid", instr_valid, 1'b0);
    step();
    chk("vec_c1", addr, 16'hFFFD);
    chk("vec_c1_valid", instr_valid, 1'b0);
    step();
    chk("vec_c2", addr, 16'h8000);
    chk("vec_c2_valid", instr_valid, 1'b0);

    k = 0;
    for (int c = 0; c < 9; c++) begin
      ev = (c == 1 || c == 4 || c == 8);
      chk($sformatf("stream_valid_c%0d", c), instr_valid, ev);
      if (ev && instr_valid && k < 3) begin
        chk("stream_op", instr_opcode, sv[k].op);
        chk("stream_op1", instr_op1, sv[k].b1);
        chk("stream_op2", instr_op2, sv[k].b2);
        chk("stream_len", instr_len, sv[k].len);
        chk("stream_pc", instr_pc, sv[k].pc);
        chk("stream_cyc", c, sv[k].cyc);
        k++;
      end
      step();
    end

    p = 16'h8006;
    for (int i = 0; i < 23; i++) begin
      wait_valid(6);
      chk($sformatf("tbl%0d_op", i), instr_opcode, lt[i].op);
      chk($sformatf("tbl%0d_len", i), instr_len, lt[i].len);
      chk($sformatf("tbl%0d_pc", i), instr_pc, p);
      chk($sformatf("tbl%0d_op1", i), instr_op1,
          (lt[i].len >= 2'd2) ? 8'h10 + 8'(i) : 8'h00);
      chk($sformatf("tbl%0d_op2", i), instr_op2,
          (lt[i].len == 2'd3) ? 8'hC0 + 8'(i) : 8'h00);
      p = p + 16'(lt[i].len);
      step();
    end

    // Backpressure
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h9000;
    step();
    redirect_valid = 1'b0;
    chk("bp_addr0", addr, 16'h9000);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", instr_valid, 1'b1);
      chk("bp_op", instr_opcode, 8'hA9);
      chk("bp_op1", instr_op1, 8'h77);
      chk("bp_addr", addr, 16'h9002);
      step();
    end
    instr_ready = 1'b1;
    chk("bp_consume_valid", instr_valid, 1'b1);
    step();
    chk("bp_after_valid", instr_valid, 1'b0);
    chk("bp_after_addr", addr, 16'h9002);
    step();
    chk("bp_next_valid", instr_valid, 1'b1);
    chk("bp_next_pc", instr_pc, 16'h9002);
    chk("bp_next_addr", addr, 16'h9003);

    // Redirect during FETCH_B1 of $4C
    redirect_valid = 1'b1;
    redirect_pc = 16'hA000;
    step();
    redirect_valid = 1'b0;
    chk("rd_a000", addr, 16'hA000);
    step();
    chk("rd_b1_addr", addr, 16'hA001);
    redirect_valid = 1'b1;
    redirect_pc = 16'hC000;
    step();
    redirect_valid = 1'b0;
    chk("rd_b1_drop_valid", instr_valid, 1'b0);
    chk("rd_b1_addr_c000", addr, 16'hC000);
    step();
    chk("rd_c000_valid", instr_valid, 1'b1);
    chk("rd_c000_pc", instr_pc, 16'hC000);
    chk("rd_c000_op", instr_opcode, 8'hEA);

    // Redirect in HOLD with ready=1: handshake completes
    chk("rd_hold_hs", {instr_valid, instr_ready}, 2'b11);
    redirect_valid = 1'b1;
    redirect_pc = 16'hC100;
    step();
    redirect_valid = 1'b0;
    chk("rd_hold_r1_valid", instr_valid, 1'b0);
    chk("rd_hold_r1_addr", addr, 16'hC100);
    step();
    step();
    chk("rd_c100_valid", instr_valid, 1'b1);
    chk("rd_c100_op", instr_opcode, 8'hA9);
    chk("rd_c100_op1", instr_op1, 8'h33);
    chk("rd_c100_pc", instr_pc, 16'hC100);

    // Redirect in HOLD with ready=0: payload discarded
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'hC200;
    step();
    redirect_valid = 1'b0;
    chk("rd_hold_r0_valid", instr_valid, 1'b0);
    chk("rd_hold_r0_addr", addr, 16'hC200);
    step();
    chk("rd_c200_valid", instr_valid, 1'b1);
    chk("rd_c200_pc", instr_pc, 16'hC200);
    chk("rd_c200_len", instr_len, 2'd1);
    instr_ready = 1'b1;

    // Wrap across $FFFF
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    chk("wr_addr0", addr, 16'hFFFE);
    step();
    chk("wr_addr1", addr, 16'hFFFF);
    step();
    chk("wr_addr2", addr, 16'h0000);
    step();
    chk("wr_valid", instr_valid, 1'b1);
    chk("wr_op", instr_opcode, 8'h20);
    chk("wr_op1", instr_op1, 8'h34);
    chk("wr_op2", instr_op2, 8'h12);
    chk("wr_len", instr_len, 2'd3);
    chk("wr_pc", instr_pc, 16'hFFFE);
    chk("wr_next_addr", addr, 16'h0001);
    step();
    chk("wr_fetch_addr", addr, 16'h0001);
    step();
    chk("wr_next_pc", instr_pc, 16'h0001);

    // Async reset mid FETCH_B2
    redirect_valid = 1'b1;
    redirect_pc = 16'hD000;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    chk("ar_b2_addr", addr, 16'hD002);
    rst = 1'b1;
    #1;
    chk("ar_addr", addr, 16'hFFFC);
    chk("ar_valid", instr_valid, 1'b0);
    chk("ar_opcode", instr_opcode, 8'h00);
    chk("ar_len", instr_len, 2'd1);
    mem[16'hFFFD] = 8'hE0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h1234;
    step();
    rst = 1'b0;
    chk("ar_c0", addr, 16'hFFFC);
    step();
    chk("ar_c1", addr, 16'hFFFD);
    step();
    chk("ar_c2", addr, 16'hE000);
    redirect_valid = 1'b0;
    step();
    chk("ar_first_valid", instr_valid, 1'b1);
    chk("ar_first_pc", instr_pc, 16'hE000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
